// File: rtl/list_split.sv
// list_split: splits one pull-based list source into a head list (A, first split_count elements) and a tail list (B).
module list_split #(
    parameter int WIDTH = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ready,
    input  logic [COUNT_WIDTH-1:0] split_count,
    output logic                   src_req,
    input  logic                   src_ack,
    input  logic [WIDTH-1:0]       src_value,
    input  logic                   src_value_valid,
    input  logic                   a_req,
    output logic                   a_ack,
    output logic [WIDTH-1:0]       a_value,
    output logic                   a_value_valid,
    input  logic                   b_req,
    output logic                   b_ack,
    output logic [WIDTH-1:0]       b_value,
    output logic                   b_value_valid
);
    localparam logic [1:0] IDLE = 2'd0, FETCH_A = 2'd1, FETCH_B = 2'd2, SKIP = 2'd3;
    localparam logic [COUNT_WIDTH-1:0] one = 1;
    logic [1:0] state;
    logic [COUNT_WIDTH-1:0] cnt, split_q, cnt_inc;
    logic src_done, a_pend, b_pend, a_want, b_want;
    // a request arriving in IDLE is served in the same cycle it is seen
    assign a_want = a_pend | a_req;
    assign b_want = b_pend | b_req;
    assign cnt_inc = cnt + one;
    always_ff @(posedge clock) begin
        src_req <= 1'b0;
        a_ack <= 1'b0;
        b_ack <= 1'b0;
        if (reset || !ready) begin
            state <= IDLE;
            cnt <= '0;
            src_done <= 1'b0;
            a_pend <= 1'b0;
            b_pend <= 1'b0;
            split_q <= split_count;
            if (reset) begin
                a_value <= '0;
                b_value <= '0;
                a_value_valid <= 1'b0;
                b_value_valid <= 1'b0;
            end
        end else begin
            a_pend <= a_want;
            b_pend <= b_want;
            case (state)
                IDLE:
                    if (a_want) begin
                        a_pend <= 1'b0;
                        if (cnt < split_q && !src_done) begin
                            src_req <= 1'b1;
                            state <= FETCH_A;
                        end else begin
                            a_ack <= 1'b1;
                            a_value_valid <= 1'b0;
                        end
                    end else if (b_want) begin
                        b_pend <= 1'b0;
                        if (src_done) begin
                            b_ack <= 1'b1;
                            b_value_valid <= 1'b0;
                        end else begin
                            src_req <= 1'b1;
                            state <= (cnt == split_q) ? FETCH_B : SKIP;
                        end
                    end
                FETCH_A:
                    if (src_ack) begin
                        a_ack <= 1'b1;
                        a_value_valid <= src_value_valid;
                        if (src_value_valid) begin
                            a_value <= src_value;
                            cnt <= cnt_inc;
                        end else begin
                            src_done <= 1'b1;
                        end
                        state <= IDLE;
                    end
                FETCH_B:
                    if (src_ack) begin
                        b_ack <= 1'b1;
                        b_value <= src_value;
                        b_value_valid <= src_value_valid;
                        if (!src_value_valid) src_done <= 1'b1;
                        state <= IDLE;
                    end
                SKIP:
                    if (src_ack) begin
                        if (src_value_valid) begin
                            cnt <= cnt_inc;
                            src_req <= 1'b1;
                            state <= (cnt_inc == split_q) ? FETCH_B : SKIP;
                        end else begin
                            src_done <= 1'b1;
                            b_ack <= 1'b1;
                            b_value_valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_list_split.sv
// tb_list_split: vector tables, corner sequences and a randomized list-level reference model for list_split.
module tb_list_split;
    logic clock = 0, reset = 1, ready = 0;
    logic [7:0] split_count = 0;
    logic src_req, src_ack = 0, src_value_valid = 0;
    logic [7:0] src_value = 0;
    logic a_req = 0, b_req = 0;
    logic a_ack, a_value_valid, b_ack, b_value_valid;
    logic [7:0] a_value, b_value;
    int total = 0, bad = 0;
    logic [7:0] src_q[$];
    int src_delay = 0, src_pulses = 0, a_acks = 0, b_acks = 0;
    int m_src[16];
    int m_len, m_rp, m_reads;

    typedef struct {
        bit on_b;
        bit ev;
        int eval;
        int elat;
    } vec_t;
    vec_t tbl[6];

    list_split dut (
        .clock(clock), .reset(reset), .ready(ready), .split_count(split_count),
        .src_req(src_req), .src_ack(src_ack), .src_value(src_value), .src_value_valid(src_value_valid),
        .a_req(a_req), .a_ack(a_ack), .a_value(a_value), .a_value_valid(a_value_valid),
        .b_req(b_req), .b_ack(b_ack), .b_value(b_value), .b_value_valid(b_value_valid)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (src_req) src_pulses++;
        if (a_ack) a_acks++;
        if (b_ack) b_acks++;
    end

    // source list: answers each src_req after src_delay cycles (0 = same cycle)
    initial forever begin
        @(negedge clock);
        src_ack = 0;
        if (src_req) begin
            repeat (src_delay) @(negedge clock);
            src_ack = 1;
            if (src_q.size() > 0) begin
                src_value = src_q.pop_front();
                src_value_valid = 1;
            end else begin
                src_value_valid = 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_req(input bit on_b, output logic v, output logic [7:0] val, output int lat);
        logic seen;
        seen = 0;
        lat = 0;
        v = 0;
        val = 0;
        if (on_b) b_req = 1;
        else a_req = 1;
        while (!seen && lat < 100) begin
            @(negedge clock);
            a_req = 0;
            b_req = 0;
            lat++;
            if (on_b ? b_ack : a_ack) begin
                seen = 1;
                v = on_b ? b_value_valid : a_value_valid;
                val = on_b ? b_value : a_value;
            end
        end
        chk("ack_seen", int'(seen), 1);
    endtask

    task automatic exp_req(input string nm, input bit on_b, input bit ev, input int eval, input int elat);
        logic v;
        logic [7:0] val;
        int lat;
        do_req(on_b, v, val, lat);
        chk({nm, ".valid"}, int'(v), int'(ev));
        if (ev) chk({nm, ".value"}, int'(val), eval);
        chk({nm, ".latency"}, lat, elat);
    endtask

    task automatic start(input int split, input int delay);
        ready = 0;
        split_count = 8'(split);
        src_delay = delay;
        repeat (2) @(negedge clock);
        ready = 1;
    endtask

    function automatic void m_read(output bit v, output int val);
        m_reads++;
        v = (m_rp < m_len);
        val = v ? m_src[m_rp] : 0;
        if (v) m_rp++;
    endfunction

    initial begin
        int p0, a0, ta, tb, va, vb, split, cnt;
        bit done, ev, rv;
        int eval, rval;
        logic v;
        logic [7:0] val;
        int lat;

        repeat (3) @(negedge clock);
        chk("reset.src_req", int'(src_req), 0);
        chk("reset.a_ack", int'(a_ack), 0);
        chk("reset.b_ack", int'(b_ack), 0);
        chk("reset.a_valid", int'(a_value_valid), 0);
        chk("reset.b_valid", int'(b_value_valid), 0);
        chk("reset.a_value", int'(a_value), 0);
        chk("reset.b_value", int'(b_value), 0);
        reset = 0;

        tbl[0] = '{0, 1, 10, 2};
        tbl[1] = '{0, 1, 11, 2};
        tbl[2] = '{0, 0, 0, 1};
        tbl[3] = '{1, 1, 12, 2};
        tbl[4] = '{1, 0, 0, 2};
        tbl[5] = '{1, 0, 0, 1};
        src_q = '{8'd10, 8'd11, 8'd12};
        start(2, 0);
        for (int i = 0; i < 6; i++) exp_req($sformatf("head_tail[%0d]", i), tbl[i].on_b, tbl[i].ev, tbl[i].eval, tbl[i].elat);

        src_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        start(3, 0);
        p0 = src_pulses;
        exp_req("tail_first.b", 1, 1, 4, 5);
        chk("tail_first.src_reqs", src_pulses - p0, 4);
        exp_req("tail_first.a_nil", 0, 0, 0, 1);

        src_q = '{8'd7};
        start(4, 0);
        exp_req("short.a0", 0, 1, 7, 2);
        exp_req("short.a1", 0, 0, 0, 2);
        p0 = src_pulses;
        exp_req("short.b_nil", 1, 0, 0, 1);
        chk("short.no_src_req", src_pulses - p0, 0);

        src_q = '{8'd20, 8'd21};
        start(1, 0);
        ta = 0; tb = 0; va = 0; vb = 0;
        a_req = 1;
        b_req = 1;
        for (int n = 1; n <= 50 && (ta == 0 || tb == 0); n++) begin
            @(negedge clock);
            a_req = 0;
            b_req = 0;
            if (a_ack) begin ta = n; va = a_value_valid ? int'(a_value) : -1; end
            if (b_ack) begin tb = n; vb = b_value_valid ? int'(b_value) : -1; end
        end
        chk("simul.a_time", ta, 2);
        chk("simul.a_value", va, 20);
        chk("simul.b_time", tb, 4);
        chk("simul.b_value", vb, 21);

        src_q = '{8'd50, 8'd51, 8'd52};
        start(0, 0);
        p0 = src_pulses;
        exp_req("zero.a_nil", 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) exp_req($sformatf("zero.b%0d", i), 1, 1, 50 + i, 2);
        exp_req("zero.b_end", 1, 0, 0, 2);
        chk("zero.src_reqs", src_pulses - p0, 4);

        src_q = '{8'd40};
        start(1, 5);
        p0 = src_pulses;
        a0 = a_acks;
        a_req = 1;
        @(negedge clock);
        a_req = 0;
        @(negedge clock);
        ready = 0;
        repeat (2) @(negedge clock);
        ready = 1;
        repeat (8) @(negedge clock);
        chk("restart.no_a_ack", a_acks - a0, 0);
        chk("restart.late_ack_sent", src_q.size(), 0);
        chk("restart.src_reqs", src_pulses - p0, 1);
        src_q = '{8'd41};
        src_delay = 0;
        exp_req("restart.refetch", 0, 1, 41, 2);

        for (int r = 0; r < 30; r++) begin
            split = $urandom_range(0, 6);
            m_len = $urandom_range(0, 8);
            src_q.delete();
            for (int i = 0; i < m_len; i++) begin
                m_src[i] = $urandom_range(0, 255);
                src_q.push_back(8'(m_src[i]));
            end
            m_rp = 0;
            m_reads = 0;
            cnt = 0;
            done = 0;
            start(split, $urandom_range(0, 3));
            p0 = src_pulses;
            for (int op = 0; op < 12; op++) begin
                bit on_b;
                on_b = 1'($urandom_range(0, 1));
                ev = 0;
                eval = 0;
                if (!on_b) begin
                    if (cnt < split && !done) begin
                        m_read(rv, rval);
                        if (rv) begin ev = 1; eval = rval; cnt++; end
                        else done = 1;
                    end
                end else if (!done) begin
                    while (cnt < split && !done) begin
                        m_read(rv, rval);
                        if (rv) cnt++;
                        else done = 1;
                    end
                    if (!done) begin
                        m_read(rv, rval);
                        if (rv) begin ev = 1; eval = rval; end
                        else done = 1;
                    end
                end
                do_req(on_b, v, val, lat);
                chk($sformatf("rand[%0d.%0d].valid", r, op), int'(v), int'(ev));
                if (ev) chk($sformatf("rand[%0d.%0d].value", r, op), int'(val), eval);
            end
            chk($sformatf("rand[%0d].src_reqs", r), src_pulses - p0, m_reads);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/list_split.md
# list_split

Splits one pull-based list stream into two: a head list carrying the first `split_count` elements of the source, and a tail list carrying the remainder. It is the inverse of the list concatenation stage. It sits between one list producer and two list consumers. It uses the same req/ack/value/value_valid protocol on every port. It answers both consumers from a single upstream source, with registered responses.

## Interface
- `WIDTH`, default 8: element width.
- `COUNT_WIDTH`, default 8: width of the split counter and of `split_count`.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `ready`  in  1  list-session enable. When low, the block restarts, with the same semantics as a session restart on the upstream side.
- `split_count`  in  COUNT_WIDTH  number of head elements. Captured while `ready`=0 or `reset`=1, and held while `ready`=1.
- `src_req`  out  1  one-cycle request to the source.
- `src_ack`, `src_value[WIDTH]`, `src_value_valid`  in  source response.
- `a_req`  in  1  head consumer request.
- `a_ack`, `a_value[WIDTH]`, `a_value_valid`  out  head response.
- `b_req`  in  1  tail consumer request.
- `b_ack`, `b_value[WIDTH]`, `b_value_valid`  out  tail response.

## Operation
- Protocol, per port:
  - req is a one-cycle pulse; at most one request is outstanding per consumer.
  - The responder answers with exactly one one-cycle ack, with value and value_valid sampled in that cycle.
  - value_valid=0 at ack means end of list (nil). Every later request on that list also returns nil.
- State held: `cnt` (head elements taken), `split_q`, `src_done`, `a_pend`, `b_pend`.
- FSM states: IDLE, FETCH_A, FETCH_B, SKIP.
- IDLE: serve pending requests, A before B.
  - A pending, `cnt`<`split_q` and !`src_done`: pulse `src_req`, go to FETCH_A.
  - A pending otherwise: issue a nil ack on A.
  - B pending with `src_done`: issue a nil ack on B.
  - B pending, `cnt`=`split_q`: pulse `src_req`, go to FETCH_B.
  - B pending, `cnt`<`split_q`: pulse `src_req`, go to SKIP.
- FETCH_A, on `src_ack`:
  - Valid element: forward it on A, increment `cnt`, go to IDLE.
  - Nil: set `src_done`, send nil on A, go to IDLE.
- FETCH_B, on `src_ack`:
  - Forward value and valid on B.
  - If nil, also set `src_done`.
  - Go to IDLE.
- SKIP, on `src_ack`:
  - Valid element: discard it and increment `cnt`. If `cnt`+1=`split_q`, pulse `src_req` and go to FETCH_B; otherwise pulse `src_req` again and stay in SKIP.
  - Nil: set `src_done`, send nil on B, go to IDLE.
- Consequence of SKIP: the head elements it discards are lost to A, and A then returns nil. Consumers drain A before B when they need the head.
- `split_count`=0: A returns nil immediately, and B sees the whole source.
- `cnt` never exceeds `split_q`; tail elements are not counted.
- After `src_done`, the block issues no further `src_req` until a restart.
- Requests arriving while busy set `a_pend`/`b_pend` and are served in IDLE.
  - Simultaneous `a_req` and `b_req`: both are latched; A is served first.
- `src_ack` outside FETCH_A/FETCH_B/SKIP is ignored.
- `ready`=0 or `reset`=1 is a restart:
  - Next state: IDLE.
  - `cnt`=0, `src_done`=0, both pending flags cleared.
  - `split_q` ← `split_count`.
  - Consumer requests and `src_ack` are ignored; an in-flight fetch is abandoned without an ack.

## Timing
- Reset values: `src_req`, `a_ack`, `b_ack`, `a_value_valid`, `b_value_valid` = 0; `a_value`, `b_value` = 0.
- Value outputs hold their last value between acks.
- All outputs are registered.
- Fetch latency: req at cycle t (block idle) → `src_req` at t+1 → `src_ack` at t+1+k (k≥0; an ack in the same cycle as `src_req` is legal) → consumer ack at t+2+k.
- Nil without fetch (head exhausted, or `src_done`): ack at t+1.
- SKIP of n elements adds n source round-trips before the FETCH_B `src_req`.
- Back-to-back: a new request may be issued in the cycle after its ack; throughput is one element per source round-trip plus 1 cycle.

## Test plan
- Head then tail:
  - Stimulus: `split_count`=2; source 10,11,12 then nil; A requested three times, then B requested three times.
  - Response: A returns 10, 11, nil. B returns 12, nil, nil.
  - Acks at fetch latency with k=0; nil-on-A at t+1.
- Tail first:
  - Stimulus: `split_count`=3, source 1..5, then B requested.
  - Response: three `src_req` pulses discarded, then B gets 4. A then returns nil at t+1.
- Short source:
  - Stimulus: `split_count`=4, source 7 then nil.
  - Response: A returns 7, nil. B returns nil with no new `src_req`.
- Simultaneous:
  - Stimulus: `split_count`=1, `a_req` and `b_req` in the same cycle, source 20,21.
  - Response: A gets 20 first, then B gets 21.
- Zero split:
  - Stimulus: `split_count`=0.
  - Response: A returns nil at t+1; B streams the full source.
- Restart:
  - Stimulus: drop `ready` during FETCH_A with the source ack delayed 5 cycles; raise `ready` again.
  - Response: no `a_ack`; late `src_ack` ignored; `cnt`=0; the next A request re-fetches from the source.
